// File: rtl/ac3_acc_bank.sv
// AC3 output-register bank: NCH saturating accumulators fed by AC2 partial sums,
// drained in channel order over a valid/ready port with clear-on-accept.
module ac3_acc_bank #(
    parameter int M   = 16,
    parameter int Pa  = 8,
    parameter int Pw  = 4,
    parameter int MNO = 288,
    parameter int NCH = 4,
    localparam int W  = $clog2(M) + Pa + Pw + $clog2(MNO),
    localparam int CW = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [CW-1:0] in_sel,
    input  logic          in_load,
    input  logic          drain_start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_ch,
    output logic          out_ovf,
    output logic          busy
);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_idx, w_idx_next;
    logic          r_in_en;
    logic [W-1:0]  r_acc [NCH];
    logic [NCH-1:0] r_ovf;
    logic          w_accept;
    logic          w_clr;

    assign w_accept = in_valid && in_ready;
    assign w_clr    = out_valid && out_ready;

    // r_in_en keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_in_en <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_in_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        in_ready     = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_ch       = '0;
        out_ovf      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = r_in_en;
                if (drain_start) begin
                    w_state_next = S_DRAIN;
                    w_idx_next   = '0;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_acc[r_idx];
                out_ch    = r_idx;
                out_ovf   = r_ovf[r_idx];
                if (out_ready) begin
                    w_idx_next = r_idx + 1'b1;
                    if (r_idx == CW'(NCH - 1)) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W:0] w_sum;
            assign w_sum = {1'b0, r_acc[gi]} + {1'b0, in_data};

            // Drain-clear and input acceptance are mutually exclusive by state.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc[gi] <= '0;
                    r_ovf[gi] <= 1'b0;
                end else if (w_clr && r_idx == CW'(gi)) begin
                    r_acc[gi] <= '0;
                    r_ovf[gi] <= 1'b0;
                end else if (w_accept && in_sel == CW'(gi)) begin
                    if (in_load) begin
                        r_acc[gi] <= in_data;
                        r_ovf[gi] <= 1'b0;
                    end else if (w_sum[W]) begin
                        r_acc[gi] <= '1;
                        r_ovf[gi] <= 1'b1;
                    end else begin
                        r_acc[gi] <= w_sum[W-1:0];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ac3_acc_bank.sv
// Directed bench for ac3_acc_bank: a 4-channel instance for the main plan and an
// 8-channel instance for the wider drain sequence.
module tb_ac3_acc_bank;

    localparam int W = 25;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_load, drain_start;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic          out_valid, out_ready, out_ovf, busy;
    logic [W-1:0]  out_data;
    logic [1:0]    out_ch;

    logic          b_in_valid, b_in_ready, b_in_load, b_drain_start;
    logic [W-1:0]  b_in_data;
    logic [2:0]    b_in_sel;
    logic          b_out_valid, b_out_ready, b_out_ovf, b_busy;
    logic [W-1:0]  b_out_data;
    logic [2:0]    b_out_ch;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_d [4];
    logic         exp_o [4];

    always #5 clk = ~clk;

    ac3_acc_bank u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_load(in_load), .drain_start(drain_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_ovf(out_ovf), .busy(busy)
    );

    ac3_acc_bank #(.NCH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_load(b_in_load), .drain_start(b_drain_start),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_ovf(b_out_ovf), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] sel, input logic [W-1:0] data, input logic load);
        in_valid = 1'b1; in_sel = sel; in_data = data; in_load = load;
        cyc();
        in_valid = 1'b0;
        $display("push ch=%0d data=%0d load=%0d", sel, data, load);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = '0;
            exp_o[i] = 1'b0;
        end
    endtask

    // Drain with out_ready held high; optionally pulse drain_start mid-drain.
    task automatic drain4(input string tag, input bit repulse);
        drain_start = 1'b1; out_ready = 1'b1;
        cyc();
        drain_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s busy%0d", tag, k), 32'(busy), 32'd1);
            check($sformatf("%s valid%0d", tag, k), 32'(out_valid), 32'd1);
            check($sformatf("%s ch%0d", tag, k), 32'(out_ch), 32'(k));
            check($sformatf("%s data%0d", tag, k), 32'(out_data), 32'(exp_d[k]));
            check($sformatf("%s ovf%0d", tag, k), 32'(out_ovf), 32'(exp_o[k]));
            $display("%s beat ch=%0d data=%0d ovf=%0d", tag, out_ch, out_data, out_ovf);
            drain_start = (repulse && k == 1);
            cyc();
            drain_start = 1'b0;
        end
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " valid_end"}, 32'(out_valid), 32'd0);
        check({tag, " ready_end"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_load = 1'b0; in_data = '0; in_sel = '0;
        drain_start = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_load = 1'b0; b_in_data = '0; b_in_sel = '0;
        b_drain_start = 1'b0; b_out_ready = 1'b0;
        cyc(); cyc();
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        check("rel in_ready", 32'(in_ready), 32'd0);
        cyc();
        check("post in_ready", 32'(in_ready), 32'd1);

        // 1: load/add/load then drain
        push(2'd0, 25'd5, 1'b1);
        push(2'd0, 25'd3, 1'b0);
        push(2'd2, 25'd100, 1'b1);
        clear_exp(); exp_d[0] = 25'd8; exp_d[2] = 25'd100;
        drain4("t1", 1'b0);

        // 2: saturation then clear by drain
        push(2'd1, 25'd33554422, 1'b1);
        push(2'd1, 25'd20, 1'b0);
        clear_exp(); exp_d[1] = 25'd33554431; exp_o[1] = 1'b1;
        drain4("t2a", 1'b0);
        clear_exp();
        drain4("t2b", 1'b0);

        // 3: input and drain_start in the same cycle
        in_valid = 1'b1; in_sel = 2'd3; in_data = 25'd7; in_load = 1'b1;
        drain_start = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0; drain_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3 ch%0d", k), 32'(out_ch), 32'(k));
            check($sformatf("t3 data%0d", k), 32'(out_data), (k == 3) ? 32'd7 : 32'd0);
            $display("t3 beat ch=%0d data=%0d", out_ch, out_data);
            cyc();
        end
        check("t3 idle", 32'(busy), 32'd0);

        // 4: backpressure at idx 1, input ignored while draining
        push(2'd1, 25'd11, 1'b1);
        push(2'd2, 25'd22, 1'b1);
        drain_start = 1'b1; out_ready = 1'b1;
        cyc();
        drain_start = 1'b0;
        check("t4 ch0", 32'(out_ch), 32'd0);
        cyc();
        out_ready = 1'b0;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 25'd99; in_load = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4 hold ch%0d", k), 32'(out_ch), 32'd1);
            check($sformatf("t4 hold data%0d", k), 32'(out_data), 32'd11);
            check($sformatf("t4 hold rdy%0d", k), 32'(in_ready), 32'd0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("t4 rel ch1", 32'(out_data), 32'd11);
        cyc();
        check("t4 ch2", 32'(out_ch), 32'd2);
        check("t4 data2", 32'(out_data), 32'd22);
        cyc();
        check("t4 ch3", 32'(out_ch), 32'd3);
        cyc();
        check("t4 idle", 32'(busy), 32'd0);
        $display("t4 backpressure sequence done");

        // 5: asynchronous reset mid-drain at idx 2
        push(2'd0, 25'd1, 1'b1);
        push(2'd1, 25'd2, 1'b1);
        push(2'd2, 25'd3, 1'b1);
        push(2'd3, 25'd4, 1'b1);
        drain_start = 1'b1; out_ready = 1'b1;
        cyc();
        drain_start = 1'b0;
        cyc(); cyc();
        check("t5 at idx2", 32'(out_ch), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5 rst valid", 32'(out_valid), 32'd0);
        check("t5 rst data", 32'(out_data), 32'd0);
        check("t5 rst busy", 32'(busy), 32'd0);
        check("t5 rst rdy", 32'(in_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        clear_exp();
        drain4("t5", 1'b0);

        // 6: drain_start during DRAIN is ignored
        push(2'd2, 25'd42, 1'b1);
        clear_exp(); exp_d[2] = 25'd42;
        drain4("t6", 1'b1);
        cyc();
        check("t6 no restart", 32'(out_valid), 32'd0);

        // 6b: eight-channel instance
        b_in_valid = 1'b1; b_in_sel = 3'd5; b_in_data = 25'd55; b_in_load = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        b_drain_start = 1'b1; b_out_ready = 1'b1;
        cyc();
        b_drain_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("n8 valid%0d", k), 32'(b_out_valid), 32'd1);
            check($sformatf("n8 ch%0d", k), 32'(b_out_ch), 32'(k));
            check($sformatf("n8 data%0d", k), 32'(b_out_data), (k == 5) ? 32'd55 : 32'd0);
            $display("n8 beat ch=%0d data=%0d", b_out_ch, b_out_data);
            cyc();
        end
        check("n8 idle", 32'(b_busy), 32'd0);
        check("n8 ready", 32'(b_in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
